// File: rtl/gmii_frame_tx.sv
`timescale 1ns/1ps
// gmii_frame_tx
// Purpose:
//    GMII Ethernet frame transmitter for the 125 MHz transmit clock domain.
//    Frame bytes (destination MAC through payload) arrive on a valid/ready
//    byte stream. The block wraps them with preamble and SFD, pads short
//    frames with 0x00, optionally appends the FCS, and enforces the
//    inter-frame gap. A source underrun or an oversized frame is aborted on
//    the wire with a single tx_er cycle. The rest of that frame is then
//    drained from the source.
// Configuration:
//    GMII_TX_FCS_EN  when defined, the CRC-32 logic and the FCS state are
//                    built, and a 4-byte FCS is appended to every good frame.
//                    When undefined, the source supplies its own FCS.
//                    Padding is still applied, and frame_done marks the
//                    last data or pad byte.
// Ports:
//    clk_125m     in   transmit clock; all logic uses the rising edge
//    rst          in   synchronous reset, active-high
//    s_valid      in   source byte valid
//    s_data[7:0]  in   source byte
//    s_last       in   final source byte of the frame
//    s_ready      out  byte accepted when s_valid & s_ready
//    txd[7:0]     out  GMII transmit data (registered)
//    tx_en        out  GMII transmit enable (registered)
//    tx_er        out  GMII transmit error (registered)
//    busy         out  high in any state except IDLE
//    frame_done   out  one-cycle pulse on the final byte of a good frame
//    frame_abort  out  one-cycle pulse coincident with tx_er
module gmii_frame_tx #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int MIN_FRAME      = 60,
   parameter int MAX_FRAME      = 1514,
   parameter int IFG_BYTES      = 12,
   parameter int LEN_W          = 11
) (
   input  logic       clk_125m,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] txd,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_abort
);

   localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_BYTES - 1);
   localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME);
   localparam logic [LEN_W-1:0] IFG_LAST = LEN_W'(IFG_BYTES - 1);
   localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d, count_inc;
   logic [7:0]       txd_q, txd_d;
   logic             tx_en_q, tx_en_d;
   logic             tx_er_q, tx_er_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_abort_q, frame_abort_d;

`ifdef GMII_TX_FCS_EN
   logic [31:0] crc_q, crc_d;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [31:0] fcs_word;

   // Reflected CRC-32 (0xEDB88320), one byte per clock, processed LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0000_0000);
      end
      return r;
   endfunction

   assign fcs_word = ~crc_q;
`endif

   // One shared counter serves three purposes: the preamble position,
   // the frame length (DATA/PAD), and the inter-frame gap length.
   assign count_inc = count_q + ONE;

   assign s_ready     = (state_q == DATA) || (state_q == DROP);
   assign busy        = (state_q != IDLE);
   assign txd         = txd_q;
   assign tx_en       = tx_en_q;
   assign tx_er       = tx_er_q;
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;

   // The outputs are computed from the current state and registered.
   // Each symbol therefore appears on the pins one edge after the state
   // that produced it.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      txd_d         = 8'h00;
      tx_en_d       = 1'b0;
      tx_er_d       = 1'b0;
      frame_done_d  = 1'b0;
      frame_abort_d = 1'b0;
`ifdef GMII_TX_FCS_EN
      crc_d         = crc_q;
      fcs_idx_d     = fcs_idx_q;
`endif
      case (state_q)
         IDLE: begin
            count_d = '0;
`ifdef GMII_TX_FCS_EN
            crc_d   = 32'hFFFF_FFFF;
`endif
            if (s_valid) begin
               state_d = PRE;
            end
         end
         PRE: begin
            txd_d   = 8'h55;
            tx_en_d = 1'b1;
            if (count_q == PRE_LAST) begin
               state_d = SFD;
               count_d = '0;
            end else begin
               count_d = count_inc;
            end
         end
         SFD: begin
            txd_d   = 8'hD5;
            tx_en_d = 1'b1;
            count_d = '0;
            state_d = DATA;
         end
         DATA: begin
            // An underrun, or a byte offered past the maximum length, is
            // aborted. The byte offered in the abort cycle is consumed.
            // If that byte ends the frame, no drain is needed.
            if (!s_valid || (count_q == MAX_LEN)) begin
               tx_en_d       = 1'b1;
               tx_er_d       = 1'b1;
               frame_abort_d = 1'b1;
               if (s_valid && s_last) begin
                  state_d = IFG;
                  count_d = '0;
               end else begin
                  state_d = DROP;
               end
            end else begin
               txd_d   = s_data;
               tx_en_d = 1'b1;
               count_d = count_inc;
`ifdef GMII_TX_FCS_EN
               crc_d   = crc_byte(crc_q, s_data);
`endif
               if (s_last) begin
                  if (count_inc < MIN_LEN) begin
                     state_d = PAD;
                  end else begin
`ifdef GMII_TX_FCS_EN
                     state_d   = FCS;
                     fcs_idx_d = 2'd0;
`else
                     state_d      = IFG;
                     count_d      = '0;
                     frame_done_d = 1'b1;
`endif
                  end
               end
            end
         end
         PAD: begin
            tx_en_d = 1'b1;
            count_d = count_inc;
`ifdef GMII_TX_FCS_EN
            crc_d   = crc_byte(crc_q, 8'h00);
`endif
            if (count_inc == MIN_LEN) begin
`ifdef GMII_TX_FCS_EN
               state_d   = FCS;
               fcs_idx_d = 2'd0;
`else
               state_d      = IFG;
               count_d      = '0;
               frame_done_d = 1'b1;
`endif
            end
         end
`ifdef GMII_TX_FCS_EN
         FCS: begin
            txd_d     = 8'(fcs_word >> {fcs_idx_q, 3'b000});
            tx_en_d   = 1'b1;
            fcs_idx_d = fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
               frame_done_d = 1'b1;
               state_d      = IFG;
               count_d      = '0;
            end
         end
`endif
         DROP: begin
            if (s_valid && s_last) begin
               state_d = IFG;
               count_d = '0;
            end
         end
         IFG: begin
            if (count_q == IFG_LAST) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
               count_d = count_inc;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // State, counter and registered GMII outputs.
   always_ff @(posedge clk_125m) begin
      if (rst) begin
         state_q       <= IDLE;
         count_q       <= '0;
         txd_q         <= 8'h00;
         tx_en_q       <= 1'b0;
         tx_er_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
`ifdef GMII_TX_FCS_EN
         crc_q         <= 32'hFFFF_FFFF;
         fcs_idx_q     <= 2'd0;
`endif
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         txd_q         <= txd_d;
         tx_en_q       <= tx_en_d;
         tx_er_q       <= tx_er_d;
         frame_done_q  <= frame_done_d;
         frame_abort_q <= frame_abort_d;
`ifdef GMII_TX_FCS_EN
         crc_q         <= crc_d;
         fcs_idx_q     <= fcs_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_gmii_frame_tx.sv
`timescale 1ns/1ps
// tb_gmii_frame_tx
// Scoreboard bench for gmii_frame_tx. The stimulus side pushes every byte
// expected on the GMII pins into a queue. A negedge monitor pops one entry
// for each tx_en cycle and compares txd, tx_er, frame_done and frame_abort.
// It also tracks the lengths of tx_en high and low runs.
module tb_gmii_frame_tx;

   localparam int PRE_N   = 7;
   localparam int MIN_N   = 60;
   localparam int MAX_N   = 1514;
   localparam int IFG_N   = 12;
   localparam int TIMEOUT = 3000;
`ifdef GMII_TX_FCS_EN
   localparam int FCS_N = 4;
`else
   localparam int FCS_N = 0;
`endif

   logic       clk_125m;
   logic       rst;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;
   logic       s_ready;
   logic [7:0] txd;
   logic       tx_en;
   logic       tx_er;
   logic       busy;
   logic       frame_done;
   logic       frame_abort;

   typedef struct packed {
      logic [7:0] d;
      logic       er;
      logic       done;
      logic       abort;
      logic       sof;
      logic       cov;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] frameBytes[$];
   int         checks    = 0;
   int         errors    = 0;
   int         lowRun    = 0;
   int         highRun   = 0;
   int         lastGap   = 0;
   int         lastHigh  = 0;

`ifdef GMII_TX_FCS_EN
   logic [31:0] crcTab[256];
   logic [31:0] obsCrc;

   // Table-driven reflected CRC-32 used for expected FCS bytes and residue.
   function automatic logic [31:0] crcUpd(input logic [31:0] c, input logic [7:0] d);
      logic [7:0] idx;
      idx = c[7:0] ^ d;
      return (c >> 8) ^ crcTab[idx];
   endfunction
`endif

   gmii_frame_tx #(
      .PREAMBLE_BYTES(PRE_N),
      .MIN_FRAME     (MIN_N),
      .MAX_FRAME     (MAX_N),
      .IFG_BYTES     (IFG_N),
      .LEN_W         (11)
   ) dut (
      .clk_125m   (clk_125m),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .txd        (txd),
      .tx_en      (tx_en),
      .tx_er      (tx_er),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_abort(frame_abort)
   );

   // 125 MHz clock.
   initial begin
      clk_125m = 1'b0;
      forever #4 clk_125m = ~clk_125m;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExp(input logic [7:0] d, input logic er, input logic done,
                          input logic abort, input logic sof, input logic cov);
      exp_t e;
      e.d = d; e.er = er; e.done = done; e.abort = abort; e.sof = sof; e.cov = cov;
      expQ.push_back(e);
   endtask

   task automatic pushPreamble();
      for (int i = 0; i < PRE_N; i++) pushExp(8'h55, 1'b0, 1'b0, 1'b0, i == 0, 1'b0);
      pushExp(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Expected wire image of a good frame built from frameBytes[0..n-1].
   task automatic expectFrame(input int n);
      int         total;
      logic [7:0] b;
`ifdef GMII_TX_FCS_EN
      logic [31:0] crc;
      logic [31:0] fcs;
      crc = 32'hFFFF_FFFF;
`endif
      total = (n < MIN_N) ? MIN_N : n;
      pushPreamble();
      for (int i = 0; i < total; i++) begin
         b = (i < n) ? frameBytes[i] : 8'h00;
         pushExp(b, 1'b0, (FCS_N == 0) && (i == total - 1), 1'b0, 1'b0, 1'b1);
`ifdef GMII_TX_FCS_EN
         crc = crcUpd(crc, b);
`endif
      end
`ifdef GMII_TX_FCS_EN
      fcs = ~crc;
      for (int k = 0; k < 4; k++) pushExp(fcs[8*k +: 8], 1'b0, k == 3, 1'b0, 1'b0, 1'b1);
`endif
   endtask

   // Expected wire image of the first k bytes, optionally followed by the abort symbol.
   task automatic expectPartial(input int k, input logic withAbort);
      pushPreamble();
      for (int i = 0; i < k; i++) pushExp(frameBytes[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (withAbort) pushExp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Presents one byte and returns #1 after the edge on which it was accepted.
   task automatic applyStimulus(input logic [7:0] b, input logic l);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = b;
      s_last  = l;
      @(negedge clk_125m);
      while (!s_ready && n < TIMEOUT) begin
         @(negedge clk_125m);
         n++;
      end
      checkOutput("s_ready wait", 32'(s_ready), 32'd1);
      @(posedge clk_125m);
      #1;
   endtask

   task automatic sendRange(input int first, input int last, input logic endFrame);
      for (int i = first; i < last; i++) applyStimulus(frameBytes[i], endFrame && (i == last - 1));
   endtask

   task automatic idleInputs();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      @(negedge clk_125m);
      while (busy && n < 5000) begin
         @(negedge clk_125m);
         n++;
      end
      checkOutput({name, " busy"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk_125m);
      checkOutput({name, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
   endtask

   // Monitor: one scoreboard entry per tx_en cycle.
   always @(negedge clk_125m) begin
      exp_t e;
      if (tx_en === 1'b1) begin
         if (highRun == 0) lastGap = lowRun;
         highRun++;
         lowRun = 0;
         if (expQ.size() == 0) begin
            checkOutput("unexpected tx_en", {24'h0, txd}, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("txd/er/done/abort", 32'({txd, tx_er, frame_done, frame_abort}),
                        32'({e.d, e.er, e.done, e.abort}));
`ifdef GMII_TX_FCS_EN
            if (e.sof) obsCrc = 32'hFFFF_FFFF;
            if (e.cov) obsCrc = crcUpd(obsCrc, txd);
            if (e.done) checkOutput("fcs residue", obsCrc, 32'hDEBB20E3);
`endif
         end
      end else begin
         if (highRun != 0) lastHigh = highRun;
         highRun = 0;
         lowRun++;
         if ((tx_er === 1'b1) || (frame_done === 1'b1) || (frame_abort === 1'b1))
            checkOutput("flags while tx_en low", 32'({tx_er, frame_done, frame_abort}), 32'd0);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
`ifdef GMII_TX_FCS_EN
      for (int n = 0; n < 256; n++) begin
         logic [31:0] c;
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crcTab[n] = c;
      end
`endif
      rst = 1'b1;
      idleInputs();
      repeat (3) @(posedge clk_125m);
      #1;
      checkOutput("reset txd", {24'h0, txd}, 32'h0);
      checkOutput("reset tx_en/er", 32'({tx_en, tx_er}), 32'h0);
      checkOutput("reset s_ready/busy", 32'({s_ready, busy}), 32'h0);
      checkOutput("reset pulses", 32'({frame_done, frame_abort}), 32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk_125m);
      #1;

      // 60-byte frame 0x00..0x3B with s_valid held high.
      $display("[TB] frame of 60 incrementing bytes");
      frameBytes.delete();
      for (int i = 0; i < 60; i++) frameBytes.push_back(8'(i));
      expectFrame(60);
      sendRange(0, 60, 1'b1);
      idleInputs();
      waitIdle("t1");
      checkOutput("t1 tx_en length", 32'(lastHigh), 32'(PRE_N + 1 + 60 + FCS_N));

      // "123456789" needs 51 pad bytes.
      $display("[TB] short frame 123456789");
      frameBytes.delete();
      for (int i = 0; i < 9; i++) frameBytes.push_back(8'h31 + 8'(i));
      expectFrame(9);
      sendRange(0, 9, 1'b1);
      idleInputs();
      waitIdle("t2");
      checkOutput("t2 tx_en length", 32'(lastHigh), 32'(PRE_N + 1 + MIN_N + FCS_N));

      // Two back-to-back frames with s_valid never dropping.
      $display("[TB] back-to-back frames");
      frameBytes.delete();
      for (int i = 0; i < 60; i++) frameBytes.push_back(8'h80 + 8'(i));
      expectFrame(60);
      sendRange(0, 60, 1'b1);
      frameBytes.delete();
      for (int i = 0; i < 61; i++) frameBytes.push_back(8'hC3 ^ 8'(i));
      expectFrame(61);
      sendRange(0, 61, 1'b1);
      idleInputs();
      waitIdle("t3");
      checkOutput("t3 idle gap", 32'(lastGap), 32'(IFG_N + 1));

      // Underrun after byte 20, then drain to s_last.
      $display("[TB] underrun abort");
      frameBytes.delete();
      for (int i = 0; i < 30; i++) frameBytes.push_back(8'hA0 + 8'(i));
      expectPartial(20, 1'b1);
      sendRange(0, 20, 1'b0);
      idleInputs();
      @(posedge clk_125m);
      #1;
      checkOutput("t4 drop s_ready", 32'({s_ready, busy}), 32'h3);
      sendRange(20, 30, 1'b1);
      idleInputs();
      waitIdle("t4");

      // Oversized 1600-byte stream.
      $display("[TB] oversized frame");
      frameBytes.delete();
      for (int i = 0; i < 1600; i++) frameBytes.push_back(8'(i * 7));
      expectPartial(MAX_N, 1'b1);
      sendRange(0, 1600, 1'b1);
      idleInputs();
      waitIdle("t5");
      checkOutput("t5 tx_en length", 32'(lastHigh), 32'(PRE_N + 1 + MAX_N + 1));

      // Reset in the middle of the data phase.
      $display("[TB] reset mid-frame");
      frameBytes.delete();
      for (int i = 0; i < 60; i++) frameBytes.push_back(8'h11 + 8'(i));
      expectPartial(30, 1'b0);
      sendRange(0, 30, 1'b0);
      rst = 1'b1;
      idleInputs();
      @(posedge clk_125m);
      #1;
      checkOutput("t6 tx_en after rst", 32'(tx_en), 32'd0);
      checkOutput("t6 busy/s_ready after rst", 32'({busy, s_ready}), 32'd0);
      repeat (2) @(posedge clk_125m);
      #1;
      rst = 1'b0;
      @(posedge clk_125m);
      #1;
      checkOutput("t6 scoreboard after rst", 32'(expQ.size()), 32'd0);
      frameBytes.delete();
      for (int i = 0; i < 64; i++) frameBytes.push_back(8'hE0 ^ 8'(i * 3));
      expectFrame(64);
      sendRange(0, 64, 1'b1);
      idleInputs();
      waitIdle("t6");
      checkOutput("t6 tx_en length", 32'(lastHigh), 32'(PRE_N + 1 + 64 + FCS_N));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
